// File: rtl/cdc_hs_pkg.sv
// Shared types and helpers for the toggle request/acknowledge crossing, source side.
// Latency: n/a. Backpressure: n/a.
// Holds the FSM state type and the wait-counter sizing function.
package cdc_hs_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    function automatic int wcnt_width(input int tmo_cyc);
        int w;
        w = $clog2(tmo_cyc + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/cdc_hs_tx_if.sv
// Word handshake plus crossing bus between producer/destination (master) and cdc_hs_tx (slave).
// Latency: n/a (wires only). Backpressure: ready gates valid; xack echoes xreq.
// The master side drives data/valid and the destination's echoed acknowledge.
interface cdc_hs_tx_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] xdata;
    logic             xreq;
    logic             xack;

    modport master (
        output data, valid, xack,
        input  ready, xdata, xreq
    );

    modport slave (
        input  data, valid, xack,
        output ready, xdata, xreq
    );
endinterface

// File: rtl/sync_2ff_n.sv
// Single-bit two-flop synchroniser, asynchronous active-low reset to 0.
// Latency: 2 clk_i edges. Backpressure: none.
// Both stages carry ASYNC_REG so placement keeps them adjacent.
module sync_2ff_n (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o
);
    (* ASYNC_REG = "TRUE" *) logic meta_q;
    (* ASYNC_REG = "TRUE" *) logic sync_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/cdc_hs_tx.sv
// Source end of a toggle req/ack crossing: captures a word, toggles xreq, waits for echoed ack.
// Latency: xdata/xreq update 1 edge after accept; loopback round trip frees ready after 4 cycles.
// Backpressure: ready low while a request is outstanding or while ack_s disagrees with xreq.
module cdc_hs_tx
    import cdc_hs_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    cdc_hs_tx_if.slave       hs,
    input  logic             clr_i,
    output logic             busy_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] xfer_cnt_o
);
    localparam int                WCNT_W = wcnt_width(TIMEOUT_CYC);
    localparam logic [WCNT_W-1:0] T_MAX  = WCNT_W'(TIMEOUT_CYC);
    localparam logic [WCNT_W-1:0] T_LAST = WCNT_W'(TIMEOUT_CYC - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   xdata_q, xdata_d;
    logic               xreq_q, xreq_d;
    logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
    logic [CNT_W-1:0]   xfer_cnt_q, xfer_cnt_d;
    logic               timeout_q, timeout_d;
    logic               tmo_set;
    logic               ack_s;
    logic               ready;

    sync_2ff_n u_ack_sync (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .d_i     (hs.xack),
        .q_o     (ack_s)
    );

    // A stale ack from an unreset destination must realign before new words go out.
    assign ready = (state_q == IDLE) && (ack_s == xreq_q);

    always_comb begin
        state_d    = state_q;
        xdata_d    = xdata_q;
        xreq_d     = xreq_q;
        wcnt_d     = wcnt_q;
        xfer_cnt_d = xfer_cnt_q;
        tmo_set    = 1'b0;
        case (state_q)
            IDLE: begin
                if (hs.valid && ready) begin
                    state_d = WAIT;
                    xdata_d = hs.data;
                    xreq_d  = ~xreq_q;
                    wcnt_d  = '0;
                end
            end
            WAIT: begin
                if (wcnt_q != T_MAX) begin
                    wcnt_d = wcnt_q + 1'b1;
                end
                // Only the edge that reaches the limit sets, so clr_i works while saturated.
                if ((TIMEOUT_CYC != 0) && (wcnt_q == T_LAST)) begin
                    tmo_set = 1'b1;
                end
                if (ack_s == xreq_q) begin
                    state_d    = IDLE;
                    xfer_cnt_d = xfer_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        timeout_d = tmo_set | (timeout_q & ~clr_i);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            xdata_q    <= '0;
            xreq_q     <= 1'b0;
            wcnt_q     <= '0;
            xfer_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            xdata_q    <= xdata_d;
            xreq_q     <= xreq_d;
            wcnt_q     <= wcnt_d;
            xfer_cnt_q <= xfer_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign hs.ready   = ready;
    assign hs.xdata   = xdata_q;
    assign hs.xreq    = xreq_q;
    assign busy_o     = (state_q == WAIT);
    assign timeout_o  = timeout_q;
    assign xfer_cnt_o = xfer_cnt_q;
endmodule
